// File: rtl/srl_fifo_prog.sv
// Shift-register FIFO with first-word-fall-through output, registered status flags,
// programmable almost-full/almost-empty levels and sticky overflow/underflow flags.
module srl_fifo_prog #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 16,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n,
    output logic [ADDR_WIDTH:0]   usedw,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow_err,
    output logic                  underflow_err
);
    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_L = CW'(DEPTH);
    localparam logic [CW-1:0] AF_L    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_L    = CW'(AE_THRESH);
    localparam logic [CW-1:0] ONE     = CW'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]         usedw_reg;
    logic [CW-1:0]         usedw_next;
    logic [CW-1:0]         rd_idx;
    logic                  full_n_reg;
    logic                  empty_n_reg;
    logic                  af_reg;
    logic                  ae_reg;
    logic                  ovf_reg;
    logic                  unf_reg;
    logic                  push;
    logic                  pop;
    logic                  ovf_try;
    logic                  unf_try;

    assign push    = if_write & if_write_ce & full_n_reg;
    assign pop     = if_read & if_read_ce & empty_n_reg;
    // Requests swallowed by a flush are not counted as errors.
    assign ovf_try = if_write & if_write_ce & ~full_n_reg & ~flush;
    assign unf_try = if_read & if_read_ce & ~empty_n_reg & ~flush;

    always_comb begin
        usedw_next = usedw_reg;
        if (flush) begin
            usedw_next = '0;
        end else if (push && !pop) begin
            usedw_next = usedw_reg + ONE;
        end else if (pop && !push) begin
            usedw_next = usedw_reg - ONE;
        end
    end

    // Data storage: newest word at index 0, oldest at usedw-1; never reset.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[0] <= if_din;
            for (int i = 1; i < DEPTH; i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            usedw_reg   <= '0;
            full_n_reg  <= 1'b1;
            empty_n_reg <= 1'b0;
            af_reg      <= 1'b0;
            ae_reg      <= 1'b1;
            ovf_reg     <= 1'b0;
            unf_reg     <= 1'b0;
        end else begin
            usedw_reg   <= usedw_next;
            full_n_reg  <= (usedw_next != DEPTH_L);
            empty_n_reg <= (usedw_next != '0);
            af_reg      <= (usedw_next >= AF_L);
            ae_reg      <= (usedw_next <= AE_L);
            if (ovf_try) begin
                ovf_reg <= 1'b1;
            end
            if (unf_try) begin
                unf_reg <= 1'b1;
            end
        end
    end

    assign rd_idx  = (usedw_reg == '0) ? '0 : (usedw_reg - ONE);
    assign if_dout = mem[rd_idx[ADDR_WIDTH-1:0]];

    assign usedw         = usedw_reg;
    assign if_full_n     = full_n_reg;
    assign if_empty_n    = empty_n_reg;
    assign almost_full   = af_reg;
    assign almost_empty  = ae_reg;
    assign overflow_err  = ovf_reg;
    assign underflow_err = unf_reg;
endmodule

// File: tb/tb_srl_fifo_prog.sv
// Bench for srl_fifo_prog (DEPTH=4): vector table plus hand-written reset/flush
// sequences; head data checked against a queue of expected words.
module tb_srl_fifo_prog;
    localparam int DW = 8;
    localparam int AW = 2;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic          if_write_ce = 1'b0;
    logic          if_write = 1'b0;
    logic [DW-1:0] if_din = '0;
    logic          if_full_n;
    logic          if_read_ce = 1'b0;
    logic          if_read = 1'b0;
    logic [DW-1:0] if_dout;
    logic          if_empty_n;
    logic [AW:0]   usedw;
    logic          almost_full;
    logic          almost_empty;
    logic          overflow_err;
    logic          underflow_err;

    int checks = 0;
    int failures = 0;
    logic [DW-1:0] sb[$];

    typedef struct {
        bit          wr;
        bit          rd;
        bit          fl;
        bit          cew;
        bit          cer;
        logic [7:0]  din;
        int          e_u;
        bit          e_ovf;
        bit          e_unf;
    } vec_t;

    vec_t tbl[18];

    srl_fifo_prog #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
        .AF_THRESH(3), .AE_THRESH(1)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .if_write_ce(if_write_ce), .if_write(if_write), .if_din(if_din),
        .if_full_n(if_full_n),
        .if_read_ce(if_read_ce), .if_read(if_read), .if_dout(if_dout),
        .if_empty_n(if_empty_n), .usedw(usedw),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .overflow_err(overflow_err), .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int e_u, input bit e_ovf, input bit e_unf);
        check({tag, " usedw"}, 32'(usedw), 32'(e_u));
        check({tag, " full_n"}, 32'(if_full_n), 32'(e_u != DEPTH));
        check({tag, " empty_n"}, 32'(if_empty_n), 32'(e_u != 0));
        check({tag, " almost_full"}, 32'(almost_full), 32'(e_u >= 3));
        check({tag, " almost_empty"}, 32'(almost_empty), 32'(e_u <= 1));
        check({tag, " overflow_err"}, 32'(overflow_err), 32'(e_ovf));
        check({tag, " underflow_err"}, 32'(underflow_err), 32'(e_unf));
        if (e_u != 0) begin
            if (sb.size() == 0) begin
                check({tag, " scoreboard_nonempty"}, 32'(sb.size()), 32'(e_u));
            end else begin
                check({tag, " dout"}, 32'(if_dout), 32'(sb[0]));
            end
        end
    endtask

    // One clock of stimulus; the scoreboard tracks acceptance from its own occupancy.
    task automatic step(input bit rst, input bit wr, input bit rd, input bit fl,
                        input bit cew, input bit cer, input logic [7:0] din);
        bit push_ok;
        bit pop_ok;
        @(negedge clk);
        reset = rst; if_write = wr; if_read = rd; flush = fl;
        if_write_ce = cew; if_read_ce = cer; if_din = din;
        push_ok = wr && cew && (sb.size() < DEPTH) && !fl && !rst;
        pop_ok  = rd && cer && (sb.size() > 0) && !fl && !rst;
        @(posedge clk);
        if (rst || fl) begin
            sb.delete();
        end else begin
            if (pop_ok) void'(sb.pop_front());
            if (push_ok) sb.push_back(din);
        end
        #1;
        reset = 1'b0; if_write = 1'b0; if_read = 1'b0; flush = 1'b0;
        $display("step rst=%0b wr=%0b rd=%0b fl=%0b din=%0h -> usedw=%0d dout=%0h ovf=%0b unf=%0b",
                 rst, wr, rd, fl, din, usedw, if_dout, overflow_err, underflow_err);
    endtask

    initial begin
        //           wr rd fl cew cer din    u ovf unf
        tbl[0]  = '{1, 0, 0, 1, 1, 8'h11, 1, 0, 0};
        tbl[1]  = '{1, 0, 0, 1, 1, 8'h22, 2, 0, 0};
        tbl[2]  = '{1, 0, 0, 1, 1, 8'h33, 3, 0, 0};
        tbl[3]  = '{1, 0, 0, 1, 1, 8'h44, 4, 0, 0};
        tbl[4]  = '{1, 0, 0, 1, 1, 8'h55, 4, 1, 0};
        tbl[5]  = '{0, 1, 0, 1, 1, 8'h00, 3, 1, 0};
        tbl[6]  = '{0, 1, 0, 1, 1, 8'h00, 2, 1, 0};
        tbl[7]  = '{0, 1, 0, 1, 1, 8'h00, 1, 1, 0};
        tbl[8]  = '{0, 1, 0, 1, 1, 8'h00, 0, 1, 0};
        tbl[9]  = '{0, 1, 0, 1, 1, 8'h00, 0, 1, 1};
        tbl[10] = '{1, 0, 0, 1, 1, 8'hA0, 1, 1, 1};
        tbl[11] = '{1, 0, 0, 1, 1, 8'hA1, 2, 1, 1};
        tbl[12] = '{1, 1, 0, 1, 1, 8'hA2, 2, 1, 1};
        tbl[13] = '{1, 0, 0, 0, 1, 8'hEE, 2, 1, 1};
        tbl[14] = '{0, 1, 0, 1, 0, 8'h00, 2, 1, 1};
        tbl[15] = '{1, 0, 0, 1, 1, 8'hB0, 3, 1, 1};
        tbl[16] = '{1, 0, 0, 1, 1, 8'hB1, 4, 1, 1};
        tbl[17] = '{1, 1, 0, 1, 1, 8'hC0, 3, 1, 1};

        step(1, 0, 0, 0, 0, 0, 8'h00);
        step(1, 0, 0, 0, 0, 0, 8'h00);
        check_all("reset", 0, 0, 0);

        // Row 12 leaves A1 at the head: the simultaneous push/pop dropped A0.
        for (int i = 0; i < 18; i++) begin
            step(0, tbl[i].wr, tbl[i].rd, tbl[i].fl, tbl[i].cew, tbl[i].cer, tbl[i].din);
            check_all($sformatf("vec%0d", i), tbl[i].e_u, tbl[i].e_ovf, tbl[i].e_unf);
        end
        check("vec12_head_a2_after_pop", 32'(if_dout), 32'h0000_00A2);

        // Fresh reset, then full FIFO with simultaneous push and pop.
        step(1, 0, 0, 0, 0, 0, 8'h00);
        check_all("rst2", 0, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            step(0, 1, 0, 0, 1, 1, 8'(i));
        end
        check_all("fill", 4, 0, 0);
        step(0, 1, 1, 0, 1, 1, 8'h05);
        check_all("full_push_pop", 3, 1, 0);
        check("full_push_pop_head", 32'(if_dout), 32'h0000_0002);

        // Flush overrides a same-cycle push; a read during flush is not an underflow.
        step(0, 1, 0, 1, 1, 1, 8'h06);
        check_all("flush_push", 0, 1, 0);
        step(0, 0, 1, 1, 1, 1, 8'h00);
        check_all("flush_read", 0, 1, 0);
        step(0, 1, 0, 0, 1, 1, 8'h77);
        check_all("after_flush_push", 1, 1, 0);
        check("after_flush_dout", 32'(if_dout), 32'h0000_0077);
        step(0, 1, 0, 0, 1, 1, 8'h78);
        check_all("pre_reset", 2, 1, 0);

        // Mid-operation reset clears contents and sticky errors.
        step(1, 1, 1, 1, 1, 1, 8'hEE);
        check_all("mid_reset", 0, 0, 0);
        step(0, 1, 0, 0, 1, 1, 8'h99);
        check_all("post_reset_push", 1, 0, 0);
        check("post_reset_dout", 32'(if_dout), 32'h0000_0099);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
